// File: rtl/mem_pkg.sv
// Shared widths and enums for the main-memory model and its arbiter.
package mem_pkg;

    localparam int LINE_W  = 128;
    localparam int ADDR_W  = 20;
    localparam int IDX_LSB = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic {
        REQ_IC,
        REQ_DC
    } req_e;

endpackage

// File: rtl/mem_ctrl_array.sv
// Single-port line store: synchronous write, registered read.
// A write also returns the written line, so write-backs echo it.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [LINE_W-1:0] wdata_i,
    output logic [LINE_W-1:0] rdata_o
);

    logic [LINE_W-1:0] mem_q [DEPTH];
    logic [LINE_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[idx_i] <= wdata_i;
                rdata_q      <= wdata_i;
            end else begin
                rdata_q      <= mem_q[idx_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_ctrl.sv
// Round-robin arbiter between icache and dcache in front of a fixed-latency
// line store. One transaction at a time; per-requester response registers.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int LATENCY   = 5,
    parameter int MEM_LINES = 1024
) (
    input  logic              clk_i,
    input  logic              rsn_i,
    input  logic              ic_rqst_i,
    input  logic [ADDR_W-1:0] ic_addr_i,
    input  logic              dc_rqst_i,
    input  logic              dc_wr_i,
    input  logic [ADDR_W-1:0] dc_addr_i,
    input  logic [LINE_W-1:0] dc_wr_data_i,
    output logic              ic_data_ready_o,
    output logic [LINE_W-1:0] ic_data_o,
    output logic [ADDR_W-1:0] ic_addr_o,
    output logic              dc_data_ready_o,
    output logic [LINE_W-1:0] dc_data_o,
    output logic [ADDR_W-1:0] dc_addr_o,
    output logic              busy_o
);

    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int CNT_W = $clog2(LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_e            state_q;
    req_e              req_q, last_q, gnt_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q, gnt_addr_d;
    logic [LINE_W-1:0] buf_q, resp_line_d, rd_line;
    logic              grant_en, arr_we;
    logic              ic_rdy_q, dc_rdy_q;
    logic [LINE_W-1:0] ic_data_q, dc_data_q;
    logic [ADDR_W-1:0] ic_addr_q, dc_addr_q;

    // DC wins a tie only when IC was granted last.
    always_comb begin
        gnt_d       = (dc_rqst_i && (!ic_rqst_i || last_q == REQ_IC)) ? REQ_DC : REQ_IC;
        gnt_addr_d  = (gnt_d == REQ_DC) ? dc_addr_i : ic_addr_i;
        grant_en    = (state_q == IDLE) && (ic_rqst_i || dc_rqst_i);
        arr_we      = grant_en && (gnt_d == REQ_DC) && dc_wr_i;
        // With LATENCY=2 the first WAIT cycle is also the last, so bypass the buffer.
        resp_line_d = (cnt_q == CNT_LOAD) ? rd_line : buf_q;
    end

    mem_array #(
        .DEPTH (MEM_LINES),
        .IDX_W (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .en_i    (grant_en),
        .we_i    (arr_we),
        .idx_i   (gnt_addr_d[IDX_LSB +: IDX_W]),
        .wdata_i (dc_wr_data_i),
        .rdata_o (rd_line)
    );

    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            state_q   <= IDLE;
            req_q     <= REQ_IC;
            last_q    <= REQ_IC;
            cnt_q     <= '0;
            addr_q    <= '0;
            buf_q     <= '0;
            ic_rdy_q  <= 1'b0;
            dc_rdy_q  <= 1'b0;
            ic_data_q <= '0;
            dc_data_q <= '0;
            ic_addr_q <= '0;
            dc_addr_q <= '0;
        end else begin
            ic_rdy_q <= 1'b0;
            dc_rdy_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_en) begin
                        req_q   <= gnt_d;
                        last_q  <= gnt_d;
                        addr_q  <= gnt_addr_d;
                        cnt_q   <= CNT_LOAD;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == CNT_LOAD) begin
                        buf_q <= rd_line;
                    end
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= RESP;
                        if (req_q == REQ_IC) begin
                            ic_rdy_q  <= 1'b1;
                            ic_data_q <= resp_line_d;
                            ic_addr_q <= addr_q;
                        end else begin
                            dc_rdy_q  <= 1'b1;
                            dc_data_q <= resp_line_d;
                            dc_addr_q <= addr_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ic_data_ready_o = ic_rdy_q;
    assign ic_data_o       = ic_data_q;
    assign ic_addr_o       = ic_addr_q;
    assign dc_data_ready_o = dc_rdy_q;
    assign dc_data_o       = dc_data_q;
    assign dc_addr_o       = dc_addr_q;
    assign busy_o          = (state_q != IDLE);

endmodule
